// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   uart_state_e  - receiver FSM state encoding (also exposed for debug)
//   DATA_BITS     - payload bits per frame
//   clks_per_bit  - system clocks per line bit for a given clock and baud rate
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input pin.
//   clk_i    - destination clock
//   rst_ni   - asynchronous active-low reset; both flops load RESET_VAL
//   d_i      - asynchronous input
//   q_o      - synchronized output, two clk_i cycles behind d_i
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling.
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   rx          - asynchronous serial line, idle high
//   data        - last correctly framed byte (LSB first on the line)
//   rx_valid    - one-cycle pulse: data holds a new byte
//   rx_busy     - high while a frame is in progress (FSM not IDLE)
//   frame_err   - one-cycle pulse: stop bit sampled low
//   parity_err  - one-cycle pulse on even-parity mismatch (0 without parity)
//   state_o     - current FSM state, for debug
// Build option: define UART_RX_PARITY_EN for 8E1 frames (an even-parity bit
// after bit 7). Left undefined, frames are 8N1 and parity_err is tied 0.
//
// Handshake: rx_valid is a single-cycle strobe with no ready; the consumer
// must capture data on the cycle rx_valid is high (data also holds its value
// until the next good frame).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output uart_state_e          state_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 bit_end_d;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  assign bit_end_d = (baud_cnt_q == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;
  logic parity_err_q;
  logic parity_bad_d;

  // Even parity: the received parity bit must equal the XOR of the data bits.
  assign parity_bad_d = par_bit_q ^ (^shift_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q    <= START;
            baud_cnt_q <= '0;
          end
        end

        // Half a bit in, confirm the line is still low; a high sample is a
        // glitch and is dropped silently.
        START: begin
          if (baud_cnt_q == HALF_M1) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

        // Counting is now aligned to mid-bit, so each full period lands on
        // the centre of the next bit.
        DATA: begin
          if (bit_end_d) begin
            baud_cnt_q         <= '0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_end_d) begin
            baud_cnt_q <= '0;
            par_bit_q  <= rx_s;
            state_q    <= STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
`endif

        // Leaving at mid stop bit leaves half a bit to catch the next start
        // edge of a back-to-back frame.
        STOP: begin
          if (bit_end_d) begin
            baud_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_bad_d;
            if (rx_s && !parity_bad_d) begin
              data_q     <= shift_q;
              rx_valid_q <= 1'b1;
            end
`else
            if (rx_s) begin
              data_q     <= shift_q;
              rx_valid_q <= 1'b1;
            end
`endif
            frame_err_q <= ~rx_s;
            state_q     <= rx_s ? IDLE : BREAK_WAIT;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

        // A line held low (break) must not be decoded as a string of 0x00s.
        BREAK_WAIT: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);
  assign state_o   = state_q;

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx, with UART_RX_PARITY_EN on or off.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;  // 16 clocks per bit
  localparam int H        = CPB / 2;
  localparam int BIG      = 32'h7fff_ffff;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  data;
  logic        rx_valid, rx_busy, frame_err, parity_err;
  uart_state_e state_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .state_o    (state_o)
  );

  // ---------------- model state ----------------
  typedef struct {
    int         cyc;
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] exp_q[$];
  int         busy_lo[$];
  int         busy_hi[$];
  logic [7:0] model_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int first_valid_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected pulse: falling start edge + 2 sync cycles + 1 detect cycle,
  // then half a bit to mid-start, then 9 (10 with parity) full bits.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            output int s);
    ev_t  e;
    logic par;
    int   pc;
    s  = cyc;
    pc = s + 3 + H + (9 + EXTRA) * CPB;
    par = ^b;
    if (!par_ok) par = ~par;
    e.cyc = pc;
    e.d   = b;
    e.fe  = !stop_ok;
`ifdef UART_RX_PARITY_EN
    e.pe = !par_ok;
    e.v  = stop_ok && par_ok;
`else
    e.pe = 1'b0;
    e.v  = stop_ok;
`endif
    ev_q.push_back(e);
    if (e.v) exp_q.push_back(b);
    busy_lo.push_back(s + 3);
    busy_hi.push_back(stop_ok ? pc : BIG);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    tick(CPB);
`endif
    rx = stop_ok;
    tick(CPB);
    if (!stop_ok) begin
      tick(CPB);
      check("break_wait_state", 32'(state_o), 32'(BREAK_WAIT));
      tick(CPB);
      rx = 1'b1;
      busy_hi[busy_hi.size() - 1] = cyc + 3;
      tick(CPB);
    end
  endtask

  task automatic send_glitch(input int len);
    busy_lo.push_back(cyc + 3);
    busy_hi.push_back(cyc + 3 + H);
    rx = 1'b0;
    tick(len);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  // Start a frame, drive nbits data bits, then reset in the middle of it.
  task automatic send_abort(input logic [7:0] b, input int nbits);
    busy_lo.push_back(cyc + 3);
    busy_hi.push_back(BIG);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      tick(CPB);
    end
    busy_hi[busy_hi.size() - 1] = cyc;
    rst_n = 1'b0;
    rx = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(2 * CPB);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic ev, efe, epe, eb;
    ev_t  e;
    if (!rst_n) begin
      check("reset_outputs", {19'd0, data, rx_valid, rx_busy, frame_err, parity_err}, 32'd0);
      model_data = 8'h00;
    end else begin
      ev = 1'b0; efe = 1'b0; epe = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        e = ev_q.pop_front();
        check("missed_event_at", 32'(e.cyc), 32'(cyc));
      end
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        e   = ev_q.pop_front();
        ev  = e.v;
        efe = e.fe;
        epe = e.pe;
        if (ev) model_data = e.d;
      end
      check("pulses{valid,ferr,perr}", {29'd0, rx_valid, frame_err, parity_err},
            {29'd0, ev, efe, epe});
      if (rx_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() > 0) check("sb_data", 32'(data), 32'(exp_q.pop_front()));
        else check("sb_unexpected_valid", 32'(rx_valid), 32'd0);
      end
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      check("data_hold", 32'(data), 32'(model_data));
      while (busy_hi.size() > 0 && busy_hi[0] <= cyc) begin
        void'(busy_lo.pop_front());
        void'(busy_hi.pop_front());
      end
      eb = (busy_lo.size() > 0) && (cyc >= busy_lo[0]);
      check("rx_busy", 32'(rx_busy), 32'(eb));
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int s0, s, v0, f0;
    logic [7:0] b;
    bit stop_ok, par_ok;
    rst_n = 1'b0;
    rx    = 1'b1;
    @(posedge clk);
    #1;
    tick(3);
    rst_n = 1'b1;
    tick(2 * CPB);

    // Single good frame: latency and data pinned with literals.
    send_frame(8'hA5, 1'b1, 1'b1, s0);
    tick(CPB);
`ifdef UART_RX_PARITY_EN
    check("first_latency", 32'(first_valid_cyc - s0), 32'd171);
`else
    check("first_latency", 32'(first_valid_cyc - s0), 32'd155);
`endif
    check("first_data", 32'(data), 32'h0000_00A5);
    check("first_valid_count", 32'(valid_cnt), 32'd1);

    // Short low glitch: no pulses at all.
    send_glitch(H - 3);
    check("glitch_valid_count", 32'(valid_cnt), 32'd1);
    check("glitch_ferr_count", 32'(fe_cnt), 32'd0);

    // Framing error with held-low line.
    send_frame(8'h3C, 1'b0, 1'b1, s);
    check("ferr_count", 32'(fe_cnt), 32'd1);
    check("ferr_data_kept", 32'(data), 32'h0000_00A5);
    check("ferr_valid_count", 32'(valid_cnt), 32'd1);

    // Back-to-back frames, no idle gap.
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, 1'b1, s);
    send_frame(8'hFF, 1'b1, 1'b1, s);
    send_frame(8'h55, 1'b1, 1'b1, s);
    tick(CPB);
    check("b2b_valid_count", 32'(valid_cnt - v0), 32'd3);
    check("b2b_last_data", 32'(data), 32'h0000_0055);

    // Reset after bit 3, then a clean frame.
    v0 = valid_cnt;
    send_abort(8'h81, 4);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, s);
    tick(CPB);
    check("post_reset_data", 32'(data), 32'h0000_0081);
    check("post_reset_valid_count", 32'(valid_cnt - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, s);
    tick(CPB);
    check("par_good_data", 32'(data), 32'h0000_0007);
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b0, s);
    tick(CPB);
    check("par_bad_perr_count", 32'(pe_cnt), 32'd1);
    check("par_bad_no_valid", 32'(valid_cnt - v0), 32'd0);
`endif

    // Randomized frames with occasional framing/parity faults and glitches.
    f0 = fe_cnt;
    for (int i = 0; i < 24; i++) begin
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 4) != 0);
      par_ok  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) send_glitch($urandom_range(1, H - 3));
      send_frame(b, stop_ok, par_ok, s);
      tick($urandom_range(0, 2 * CPB));
    end

    tick(4 * CPB);
    check("events_drained", 32'(ev_q.size()), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("idle_at_end", 32'(rx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
